spi_device_reg_access: RTL

//  SPI slave front-end for the device config register file. Per transaction it shifts
//  in an 8-bit opcode, then either:
//   - drives write strobes (wr_addr/wr_data/wr_data_valid) into the register file, or
//   - reads rd_data at rd_addr and shifts it out.

---
 rtl/spi_device_reg_access_if.sv | 32 +++
 rtl/spi_device_reg_access.sv | 129 ++++++++++++
 2 files changed

// File: rtl/spi_device_reg_access_if.sv
// Register-file side of the SPI device block: write strobes out, read address out,
// combinational read data and the quad-lane enable back in.
interface spi_device_reg_access_if #(
    parameter int REG_SIZE = 8
);
    logic                en_qpi;
    logic [1:0]          wr_addr;
    logic [REG_SIZE-1:0] wr_data;
    logic                wr_data_valid;
    logic [1:0]          rd_addr;
    logic [REG_SIZE-1:0] rd_data;

    // wr_data_valid is a one-cycle strobe with no ready: the register file must
    // take wr_addr/wr_data on the posedge that ends the cycle in which it is high.
    modport master (
        input  en_qpi,
        input  rd_data,
        output wr_addr,
        output wr_data,
        output wr_data_valid,
        output rd_addr
    );

    modport slave (
        output en_qpi,
        output rd_data,
        input  wr_addr,
        input  wr_data,
        input  wr_data_valid,
        input  rd_addr
    );
endinterface

// File: rtl/spi_device_reg_access.sv
// SPI slave front-end for the config register file: 8-bit opcode, then a write
// stream or a read stream, single-bit or quad lanes, everything in the sclk domain.
module spi_device_reg_access #(
    parameter int REG_SIZE = 8
) (
    input  logic                           sclk,
    input  logic                           rstn,
    input  logic [3:0]                     sdi,
    output logic [3:0]                     sdo,
    output logic [3:0]                     sdo_oe,
    spi_device_reg_access_if.master        rf,
    output logic [2:0]                     dbg_state
);
    typedef enum logic [2:0] {
        ST_CMD    = 3'd0,
        ST_WDATA  = 3'd1,
        ST_RTA    = 3'd2,
        ST_RDATA  = 3'd3,
        ST_IGNORE = 3'd4
    } state_t;

    localparam int CW = (REG_SIZE > 8) ? $clog2(REG_SIZE) : 3;
    localparam logic [CW-1:0] CMD_LAST_S = CW'(7);
    localparam logic [CW-1:0] CMD_LAST_Q = CW'(1);
    localparam logic [CW-1:0] DAT_LAST_S = CW'(REG_SIZE - 1);
    localparam logic [CW-1:0] DAT_LAST_Q = CW'(REG_SIZE / 4 - 1);

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       bitcnt;
    logic [REG_SIZE-2:0] rx_sr;
    logic [REG_SIZE-1:0] rx_nxt;
    logic [REG_SIZE-1:0] tx_sr;
    logic [1:0]          addr;
    logic [1:0]          rd_addr_q;
    logic                cmd_last;
    logic                dat_last;
    logic                cmd_ok;

    // The opcode is always 8 bits; only the data bytes follow REG_SIZE.
    assign cmd_last = rf.en_qpi ? (bitcnt == CMD_LAST_Q) : (bitcnt == CMD_LAST_S);
    assign dat_last = rf.en_qpi ? (bitcnt == DAT_LAST_Q) : (bitcnt == DAT_LAST_S);
    assign rx_nxt   = rf.en_qpi ? {rx_sr[REG_SIZE-5:0], sdi} : {rx_sr, sdi[0]};
    assign cmd_ok   = (rx_nxt[7:3] == 5'b01110);

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) state <= ST_CMD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        rf.wr_data_valid = 1'b0;
        rf.wr_data       = rx_nxt;
        rf.wr_addr       = addr;
        sdo              = 4'h0;
        sdo_oe           = 4'h0;
        case (state)
            ST_CMD: begin
                if (cmd_last) begin
                    if (!cmd_ok)        state_nxt = ST_IGNORE;
                    else if (rx_nxt[2]) state_nxt = ST_RTA;
                    else                state_nxt = ST_WDATA;
                end
            end
            ST_WDATA: rf.wr_data_valid = dat_last;
            ST_RTA:   state_nxt = ST_RDATA;
            ST_RDATA: begin
                if (rf.en_qpi) begin
                    sdo    = tx_sr[REG_SIZE-1 -: 4];
                    sdo_oe = 4'hF;
                end else begin
                    sdo    = {2'b00, tx_sr[REG_SIZE-1], 1'b0};
                    sdo_oe = 4'b0010;
                end
            end
            default: ;
        endcase
    end

    // Datapath: shift registers, byte counter and the auto-incrementing address.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            bitcnt    <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            addr      <= 2'd0;
            rd_addr_q <= 2'd0;
        end else begin
            case (state)
                ST_CMD: begin
                    rx_sr  <= rx_nxt[REG_SIZE-2:0];
                    bitcnt <= cmd_last ? '0 : bitcnt + CW'(1);
                    if (cmd_last) begin
                        addr      <= rx_nxt[1:0];
                        rd_addr_q <= rx_nxt[1:0];
                    end
                end
                ST_WDATA: begin
                    rx_sr  <= rx_nxt[REG_SIZE-2:0];
                    bitcnt <= dat_last ? '0 : bitcnt + CW'(1);
                    if (dat_last) addr <= addr + 2'd1;
                end
                ST_RTA: begin
                    tx_sr     <= rf.rd_data;
                    bitcnt    <= '0;
                    addr      <= addr + 2'd1;
                    rd_addr_q <= addr + 2'd1;
                end
                ST_RDATA: begin
                    if (dat_last) begin
                        // Next byte is already addressed, so the stream never stalls.
                        tx_sr     <= rf.rd_data;
                        bitcnt    <= '0;
                        addr      <= addr + 2'd1;
                        rd_addr_q <= addr + 2'd1;
                    end else begin
                        tx_sr  <= rf.en_qpi ? (tx_sr << 4) : (tx_sr << 1);
                        bitcnt <= bitcnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rf.rd_addr = rd_addr_q;
    assign dbg_state  = state;
endmodule
